// File: rtl/wfg_drive_spi_pkg.sv
// Shared types for the SPI output driver: FSM states and frame-size encodings.
// No logic; latency and backpressure are defined by the core that imports it.
package wfg_drive_spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } spi_state_t;

   localparam logic [1:0] DSZ_8  = 2'd0;
   localparam logic [1:0] DSZ_16 = 2'd1;
   localparam logic [1:0] DSZ_24 = 2'd2;
   localparam logic [1:0] DSZ_32 = 2'd3;

   function automatic logic [6:0] dsz_to_bits(input logic [1:0] dsz);
      case (dsz)
         DSZ_8:   return 7'd8;
         DSZ_16:  return 7'd16;
         DSZ_24:  return 7'd24;
         DSZ_32:  return 7'd32;
         default: return 7'd32;
      endcase
   endfunction

endpackage

// File: rtl/wfg_drive_spi_core.sv
// SPI master (CPHA=0) serialising one stimulus sample per core sync; outputs registered, 1 clk after sync/tick.
// Ready is combinational and only in IDLE on an enabled sync; missing or early samples raise underrun/overrun.
module wfg_drive_spi_core
   import wfg_drive_spi_pkg::*;
#(
   parameter int unsigned DATAW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             cfg_cpol_i,
   input  logic             cfg_lsbfirst_i,
   input  logic [1:0]       cfg_dsz_i,
   input  logic             wfg_pat_sync_i,
   input  logic             wfg_pat_subcycle_i,
   input  logic             wfg_stim_valid_i,
   input  logic [DATAW-1:0] wfg_stim_data_i,
   output logic             wfg_stim_ready_o,
   output logic             spi_sclk_o,
   output logic             spi_cs_n_o,
   output logic             spi_sdo_o,
   output logic             busy_o,
   output logic             underrun_o,
   output logic             overrun_o
);

   spi_state_t       state, state_nxt;
   logic [DATAW-1:0] shreg;
   logic [DATAW-1:0] aligned;
   logic [6:0]       edge_cnt, edge_nxt;
   logic [6:0]       nbits, nbits_load, two_n;
   logic             cpol_q, lsb_q;
   logic             load;

   always_comb begin
      nbits_load       = dsz_to_bits(cfg_dsz_i);
      // MSB-first frames are left-aligned so the outgoing bit is always the top bit
      aligned          = wfg_stim_data_i << (7'(DATAW) - nbits_load);
      edge_nxt         = edge_cnt + 7'd1;
      two_n            = {nbits[5:0], 1'b0};
      load             = (state == IDLE) & en_i & wfg_pat_sync_i & wfg_stim_valid_i;
      wfg_stim_ready_o = load;
      state_nxt        = state;
      if (!en_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (wfg_pat_subcycle_i && edge_nxt == two_n) state_nxt = HOLD;
            HOLD:    if (wfg_pat_subcycle_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         edge_cnt   <= '0;
         nbits      <= '0;
         cpol_q     <= 1'b0;
         lsb_q      <= 1'b0;
         spi_sclk_o <= 1'b0;
         spi_cs_n_o <= 1'b1;
         spi_sdo_o  <= 1'b0;
         underrun_o <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         state      <= state_nxt;
         underrun_o <= (state == IDLE) & en_i & wfg_pat_sync_i & ~wfg_stim_valid_i;
         overrun_o  <= (state != IDLE) & en_i & wfg_pat_sync_i;
         if (!en_i) begin
            spi_cs_n_o <= 1'b1;
            spi_sdo_o  <= 1'b0;
            edge_cnt   <= '0;
            spi_sclk_o <= (state == IDLE) ? cfg_cpol_i : cpol_q;
         end else begin
            case (state)
               IDLE: begin
                  spi_sclk_o <= cfg_cpol_i;
                  spi_cs_n_o <= 1'b1;
                  spi_sdo_o  <= 1'b0;
                  if (load) begin
                     cpol_q     <= cfg_cpol_i;
                     lsb_q      <= cfg_lsbfirst_i;
                     nbits      <= nbits_load;
                     edge_cnt   <= '0;
                     spi_cs_n_o <= 1'b0;
                     if (cfg_lsbfirst_i) begin
                        shreg     <= wfg_stim_data_i;
                        spi_sdo_o <= wfg_stim_data_i[0];
                     end else begin
                        shreg     <= aligned;
                        spi_sdo_o <= aligned[DATAW-1];
                     end
                  end
               end
               SHIFT: begin
                  if (wfg_pat_subcycle_i) begin
                     spi_sclk_o <= ~spi_sclk_o;
                     edge_cnt   <= edge_nxt;
                     // trailing edges move to the next bit, except the last one
                     if (!edge_nxt[0] && edge_nxt != two_n) begin
                        if (lsb_q) begin
                           shreg     <= shreg >> 1;
                           spi_sdo_o <= shreg[1];
                        end else begin
                           shreg     <= shreg << 1;
                           spi_sdo_o <= shreg[DATAW-2];
                        end
                     end
                  end
               end
               HOLD: begin
                  if (wfg_pat_subcycle_i) begin
                     spi_cs_n_o <= 1'b1;
                     spi_sdo_o  <= 1'b0;
                  end
               end
               default: begin
                  spi_cs_n_o <= 1'b1;
                  spi_sdo_o  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wfg_drive_spi_core.sv
// Directed bench for the SPI driver: table of frames plus hand-written corner sequences.
module tb_wfg_drive_spi_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        cpol;
   logic        lsb;
   logic [1:0]  dsz;
   logic        sync;
   logic        sub;
   logic        valid;
   logic [31:0] data;
   logic        ready;
   logic        sclk;
   logic        cs_n;
   logic        sdo;
   logic        busy;
   logic        underrun;
   logic        overrun;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wfg_drive_spi_core #(.DATAW(32)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .en_i               (en),
      .cfg_cpol_i         (cpol),
      .cfg_lsbfirst_i     (lsb),
      .cfg_dsz_i          (dsz),
      .wfg_pat_sync_i     (sync),
      .wfg_pat_subcycle_i (sub),
      .wfg_stim_valid_i   (valid),
      .wfg_stim_data_i    (data),
      .wfg_stim_ready_o   (ready),
      .spi_sclk_o         (sclk),
      .spi_cs_n_o         (cs_n),
      .spi_sdo_o          (sdo),
      .busy_o             (busy),
      .underrun_o         (underrun),
      .overrun_o          (overrun)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  dsz;
      int          nbits;
      logic        lsb;
      logic        cpol;
      logic        tick0;
      logic        scramble;
      int          sync2;
      logic [31:0] exp_word;
      int          exp_edges;
      int          exp_cslow;
      int          exp_ovr;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          t_len;
      int          edges;
      int          cslow;
      int          rdy;
      int          ovr;
      logic [31:0] word;
      logic        prev;
      t_len = 4 * (2 * v.nbits + 1);
      edges = 0; cslow = 0; rdy = 0; ovr = 0; word = '0;
      // settle IDLE sclk on the new polarity before the frame starts
      en = 1'b1; cpol = v.cpol; lsb = v.lsb; dsz = v.dsz;
      sync = 1'b0; sub = 1'b0; valid = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk($sformatf("v%0d_idle_sclk", idx), 32'(sclk), 32'(v.cpol));
      prev = sclk;
      next_cycle();
      for (int c = 0; c <= t_len + 3; c++) begin
         en    = 1'b1;
         sync  = (c == 0) || (c == v.sync2);
         valid = sync;
         sub   = ((c > 0) && (c % 4 == 0) && (c <= t_len)) || ((c == 0) && v.tick0);
         data  = (c == 0) ? v.data : ~v.data;
         if (v.scramble && c >= 1 && c <= t_len) begin
            cpol = ~v.cpol; lsb = ~v.lsb; dsz = ~v.dsz;
         end else begin
            cpol = v.cpol; lsb = v.lsb; dsz = v.dsz;
         end
         @(negedge clk);
         if (ready) rdy++;
         if (overrun) ovr++;
         if (!cs_n) begin
            cslow++;
            if (sclk !== prev) begin
               edges++;
               if (sclk !== v.cpol) word = {word[30:0], sdo};
            end
         end
         prev = sclk;
         next_cycle();
      end
      sync = 1'b0; valid = 1'b0; sub = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_word", idx), word, v.exp_word);
      chk($sformatf("v%0d_edges", idx), 32'(edges), 32'(v.exp_edges));
      chk($sformatf("v%0d_cs_low", idx), 32'(cslow), 32'(v.exp_cslow));
      chk($sformatf("v%0d_ready", idx), 32'(rdy), 32'd1);
      chk($sformatf("v%0d_overrun", idx), 32'(ovr), 32'(v.exp_ovr));
      chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d_cs_end", idx), 32'(cs_n), 32'd1);
      chk($sformatf("v%0d_sclk_end", idx), 32'(sclk), 32'(v.cpol));
      next_cycle();
   endtask

   initial begin
      vecs[0] = '{32'h0000_00A5, 2'd0,  8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0000_00A5, 16,  68, 0};
      vecs[1] = '{32'h8000_0001, 2'd3, 32, 1'b1, 1'b1, 1'b0, 1'b0, -1, 32'h8000_0001, 64, 260, 0};
      vecs[2] = '{32'h1234_ABCD, 2'd1, 16, 1'b0, 1'b0, 1'b1, 1'b0, -1, 32'h0000_ABCD, 32, 132, 0};
      vecs[3] = '{32'h0000_0001, 2'd0,  8, 1'b1, 1'b1, 1'b0, 1'b1, -1, 32'h0000_0080, 16,  68, 0};
      vecs[4] = '{32'hFF12_3456, 2'd2, 24, 1'b0, 1'b1, 1'b0, 1'b0, -1, 32'h0012_3456, 48, 196, 0};
      vecs[5] = '{32'h0000_0003, 2'd1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 20, 32'h0000_C000, 32, 132, 1};
      vecs[6] = '{32'h0000_003C, 2'd0,  8, 1'b0, 1'b0, 1'b0, 1'b0, 68, 32'h0000_003C, 16,  68, 1};
      vecs[7] = '{32'hDEAD_BEEF, 2'd3, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32'hDEAD_BEEF, 64, 260, 0};

      rst_n = 1'b0; en = 1'b0; cpol = 1'b1; lsb = 1'b0; dsz = 2'd0;
      sync = 1'b0; sub = 1'b0; valid = 1'b0; data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_sdo", 32'(sdo), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      rst_n = 1'b1;
      next_cycle();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // sync without a sample
      en = 1'b1; cpol = 1'b0; sync = 1'b1; valid = 1'b0;
      @(negedge clk);
      chk("udr_ready", 32'(ready), 32'd0);
      next_cycle();
      sync = 1'b0;
      @(negedge clk);
      chk("udr_pulse", 32'(underrun), 32'd1);
      chk("udr_cs_n", 32'(cs_n), 32'd1);
      chk("udr_busy", 32'(busy), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("udr_pulse_end", 32'(underrun), 32'd0);
      next_cycle();

      // enable dropped on tick 7 of a 16-bit frame
      cpol = 1'b1; lsb = 1'b0; dsz = 2'd1; data = 32'h0000_FFFF;
      next_cycle();
      next_cycle();
      for (int c = 0; c <= 28; c++) begin
         en    = (c < 28);
         sync  = (c == 0);
         valid = (c == 0);
         sub   = (c > 0) && (c % 4 == 0);
         if (c == 27) begin
            @(negedge clk);
            chk("en_cs_active", 32'(cs_n), 32'd0);
         end
         next_cycle();
      end
      sub = 1'b0;
      @(negedge clk);
      chk("en_cs_n", 32'(cs_n), 32'd1);
      chk("en_sclk", 32'(sclk), 32'd1);
      chk("en_busy", 32'(busy), 32'd0);
      chk("en_sdo", 32'(sdo), 32'd0);
      chk("en_overrun", 32'(overrun), 32'd0);
      next_cycle();
      sync = 1'b1; valid = 1'b1;
      @(negedge clk);
      chk("en_off_ready", 32'(ready), 32'd0);
      next_cycle();
      sync = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("en_off_underrun", 32'(underrun), 32'd0);
      chk("en_off_cs_n", 32'(cs_n), 32'd1);
      next_cycle();
      run_vec(vecs[0], 8);

      // asynchronous reset during tick 3 of a cpol=1 frame
      en = 1'b1; cpol = 1'b1; lsb = 1'b0; dsz = 2'd0; data = 32'h0000_00FF;
      next_cycle();
      next_cycle();
      for (int c = 0; c < 12; c++) begin
         sync  = (c == 0);
         valid = (c == 0);
         sub   = (c > 0) && (c % 4 == 0);
         if (c == 11) begin
            @(negedge clk);
            chk("ar_cs_active", 32'(cs_n), 32'd0);
            chk("ar_sclk_before", 32'(sclk), 32'd1);
         end
         next_cycle();
      end
      sub = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_cs_n", 32'(cs_n), 32'd1);
      chk("ar_sclk", 32'(sclk), 32'd0);
      chk("ar_sdo", 32'(sdo), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      next_cycle();
      sub = 1'b0;
      rst_n = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("ar_idle_sclk", 32'(sclk), 32'd1);
      chk("ar_idle_cs_n", 32'(cs_n), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
